// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the EX/MEM pipeline stage register.
//   PIPE_DATA_W / PIPE_CTRL_W : default payload / control widths
//   MEM_READ .. REG_WRITE     : bit positions inside the EX/MEM control field
//   slot_op_e                 : per-cycle operation applied to one holding slot
//   occ_count()               : number of valid slots
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Payload is PC_Branch(32) + zero(1) + result(32) + Write_Data(32) + rd(5).
    localparam int unsigned PIPE_DATA_W = 102;
    localparam int unsigned PIPE_CTRL_W = 5;

    // EX/MEM control-bit indices.
    localparam int unsigned MEM_READ   = 0;
    localparam int unsigned MEM_WRITE  = 1;
    localparam int unsigned PC_SRC     = 2;
    localparam int unsigned MEM_TO_REG = 3;
    localparam int unsigned REG_WRITE  = 4;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_e;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One holding entry: valid bit plus control and payload registers.
//   clk, rst_n        : clock, synchronous active-low reset
//   load              : capture ld_ctrl/ld_data and set valid (wins over clear)
//   clear             : drop valid and zero the control bits; payload holds
//   ld_ctrl, ld_data  : value to capture on load
//   valid, ctrl, data : registered slot contents
// ---------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Slot state: control bits are zeroed whenever the slot is empty so a
    // bubble can never carry a stale write/read enable downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{1'b0}};
            data  <= {DATA_W{1'b0}};
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{1'b0}};
            data  <= data;
        end else begin
            valid <= valid;
            ctrl  <= ctrl;
            data  <= data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register with optional two-entry skid buffer.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_ctrl, in_data    : upstream control bits / payload
//   flush               : drop every held and incoming beat
//   out_valid/out_ready : downstream handshake
//   out_ctrl, out_data  : downstream control bits / payload (ctrl is zero
//                         whenever out_valid is low)
//   occupancy           : number of held beats (0..2)
// SKID=1 gives a registered in_ready (no path from out_ready); SKID=0 gives a
// single entry whose in_ready follows out_ready combinationally.
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic              skid_valid_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;

    logic              in_ready_s;
    logic              accept_s;
    logic              drain_s;
    slot_op_e          main_op_s;
    slot_op_e          skid_op_s;
    logic              main_from_skid_s;
    logic              main_load_s;
    logic              main_clear_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic              main_valid_next_s;
    logic              skid_valid_next_s;
    logic [CTRL_W-1:0] main_ld_ctrl_s;
    logic [DATA_W-1:0] main_ld_data_s;
    logic [1:0]        occ_r;

    assign accept_s = in_valid & in_ready_s & ~flush;
    assign drain_s  = main_valid_s & out_ready;

    // Slot operation selection. Skid-full implies in_ready=0, so no accept
    // can coincide with a skid-to-main move.
    always_comb begin
        main_op_s        = SLOT_HOLD;
        skid_op_s        = SLOT_HOLD;
        main_from_skid_s = 1'b0;
        if (flush) begin
            main_op_s = SLOT_CLEAR;
            skid_op_s = SLOT_CLEAR;
        end else if (skid_valid_s) begin
            if (drain_s) begin
                main_op_s        = SLOT_LOAD;
                main_from_skid_s = 1'b1;
                skid_op_s        = SLOT_CLEAR;
            end else begin
                main_op_s = SLOT_HOLD;
            end
        end else if (main_valid_s) begin
            if (drain_s && accept_s) begin
                main_op_s = SLOT_LOAD;
            end else if (drain_s) begin
                main_op_s = SLOT_CLEAR;
            end else if (accept_s) begin
                skid_op_s = SLOT_LOAD;
            end else begin
                main_op_s = SLOT_HOLD;
            end
        end else begin
            if (accept_s) begin
                main_op_s = SLOT_LOAD;
            end else begin
                main_op_s = SLOT_HOLD;
            end
        end
    end

    // Decode slot operations into load/clear strobes and next valid bits.
    always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        case (main_op_s)
            SLOT_LOAD:  main_load_s  = 1'b1;
            SLOT_CLEAR: main_clear_s = 1'b1;
            default:    main_load_s  = 1'b0;
        endcase
        case (skid_op_s)
            SLOT_LOAD:  skid_load_s  = 1'b1;
            SLOT_CLEAR: skid_clear_s = 1'b1;
            default:    skid_load_s  = 1'b0;
        endcase
        main_valid_next_s = main_load_s | (main_valid_s & ~main_clear_s);
        skid_valid_next_s = skid_load_s | (skid_valid_s & ~skid_clear_s);
    end

    // Main entry loads either the incoming beat or the promoted skid beat.
    always_comb begin
        if (main_from_skid_s) begin
            main_ld_ctrl_s = skid_ctrl_s;
            main_ld_data_s = skid_data_s;
        end else begin
            main_ld_ctrl_s = in_ctrl;
            main_ld_data_s = in_data;
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load_s),
        .clear   (main_clear_s),
        .ld_ctrl (main_ld_ctrl_s),
        .ld_data (main_ld_data_s),
        .valid   (main_valid_s),
        .ctrl    (main_ctrl_s),
        .data    (main_data_s)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic ready_r;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (skid_load_s),
                .clear   (skid_clear_s),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .valid   (skid_valid_s),
                .ctrl    (skid_ctrl_s),
                .data    (skid_data_s)
            );

            // Registered ready: high whenever the skid entry will be empty.
            // It resets high so in_ready rises on the very first cycle after
            // release; the rst_n gate keeps it low while reset is held.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ready_r <= 1'b1;
                end else begin
                    ready_r <= ~skid_valid_next_s;
                end
            end

            assign in_ready_s = rst_n & ready_r;
        end else begin : g_noskid
            logic unused_skid_s;

            assign skid_valid_s  = 1'b0;
            assign skid_ctrl_s   = {CTRL_W{1'b0}};
            assign skid_data_s   = {DATA_W{1'b0}};
            assign unused_skid_s = skid_load_s ^ skid_clear_s ^ skid_valid_next_s;
            assign in_ready_s    = rst_n & (out_ready | ~main_valid_s);
        end
    endgenerate

    // Occupancy tracks the slot valid bits as they will stand after the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_r <= 2'd0;
        end else begin
            occ_r <= occ_count(main_valid_next_s, skid_valid_next_s);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = main_valid_s;
    assign out_ctrl  = main_ctrl_s;
    assign out_data  = main_data_s;
    assign occupancy = occ_r;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 102, meaning payload width (PC_Branch 32 + zero 1 + result 32 + Write_Data 32 + rd 5).
REQ-002 Parameter CTRL_W, default 5, meaning control-bit width; these bits are zeroed on any bubble.
REQ-003 Parameter SKID, default 1, meaning 1 = two-entry skid with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  meaning synchronous, active-low reset.
REQ-006 in_valid  input  1  meaning the upstream beat is present.
REQ-007 in_ready  output  1  meaning the stage accepts a beat this cycle.
REQ-008 in_ctrl  input  CTRL_W  meaning upstream control bits.
REQ-009 in_data  input  DATA_W  meaning upstream payload.
REQ-010 flush  input  1  meaning discard all held and incoming beats.
REQ-011 out_valid  output  1  meaning the downstream beat is present.
REQ-012 out_ready  input  1  meaning downstream accepts the beat.
REQ-013 out_ctrl  output  CTRL_W  meaning downstream control bits.
REQ-014 out_data  output  DATA_W  meaning downstream payload.
REQ-015 occupancy  output  2  meaning number of held beats, 0..2.

Function
REQ-016 Accept occurs on any cycle with in_valid=1, in_ready=1 and flush=0; drain occurs on any cycle with out_valid=1 and out_ready=1.
REQ-017 A beat accepted at edge N shall appear on out_valid/out_ctrl/out_data immediately after edge N (one-cycle latency).
REQ-018 The stage shall preserve beat order and never duplicate or drop an accepted beat except on flush.
REQ-019 With SKID=1, in_ready shall equal NOT skid_full, driven from a register with no combinational path from out_ready.
REQ-020 With SKID=1, a beat accepted while the main entry is full and not draining shall go to the skid entry.
REQ-021 With SKID=1, a drain while the skid entry is full shall move skid to main, and in_ready shall be 1 the next cycle.
REQ-022 A simultaneous accept and drain with only the main entry full shall load main with the new beat, leaving the skid entry empty.
REQ-023 With SKID=0, in_ready shall equal out_ready OR NOT out_valid (combinational), and occupancy shall never exceed 1.
REQ-024 flush=1 at an edge shall invalidate both entries and discard any beat presented that cycle; flush has priority over accept and drain.
REQ-025 Whenever out_valid=0, out_ctrl shall be all zero (bubble-safe); out_data shall hold its last value.
REQ-026 Held payload shall not change while out_valid=1 and out_ready=0 (stall).
REQ-027 occupancy shall equal main_valid + skid_valid after every edge.

Reset
REQ-028 rst_n=0 at an edge shall clear both valid bits, out_ctrl, out_data and occupancy to 0.
REQ-029 in_ready shall be 0 while rst_n=0 and 1 on the first cycle after reset release.
REQ-030 Reset mid-operation shall discard held beats exactly as flush does; no beat emerges after reset release unless accepted afterwards.

Structure
REQ-031 Shared package pipe_pkg shall hold the default DATA_W/CTRL_W constants and the EX/MEM control-bit indices (MEM_READ, MEM_WRITE, PC_SRC, MEM_TO_REG, REG_WRITE).
REQ-032 One sub-module, pipe_slot (valid bit plus ctrl/data register with load/clear), shall be instantiated once for main and, when SKID=1, once for skid.

Verification
REQ-033 Reset, then in_valid=1 with data 0xA1, out_ready=1 -> out_valid=1 with data 0xA1 one cycle later; occupancy=1.
REQ-034 Stall: out_ready=0, push 0xB1, 0xB2 -> occupancy=2 and in_ready=0; then out_ready=1 -> 0xB1, then 0xB2, in order; in_ready returns to 1.
REQ-035 Streaming at in_valid=out_ready=1 for 16 beats 0..15 -> 16 consecutive outputs with no gaps, and occupancy stays 1.
REQ-036 flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed beats never appear.
REQ-037 rst_n=0 asserted mid-stall with 2 held beats -> occupancy=0 and in_ready=0 during reset; after release in_ready=1 and no stale output.
REQ-038 SKID=0 build, out_ready=0 while full -> in_ready=0 combinationally; out_ready=1 with in_valid=1 -> accept and drain in the same cycle.
